// File: rtl/spi_slave_regs.sv
// -----------------------------------------------------------------------------
// spi_slave_regs
//
// SPI (mode 0, MSB first) slave in front of a 2**ADDR_W x 8-bit register file,
// with a second local read/write port on the system clock. sclk, mosi and ss_n
// arrive asynchronously and are brought into the clk domain through 2-FF
// synchronisers; every protocol edge is detected on the synchronised values,
// so sclk must be no faster than clk/8.
//
// Frame format (ss_n low for the whole frame):
//   byte 0 : command  8'h0A = write, 8'h0B = read, anything else is ignored
//   byte 1 : address  low ADDR_W bits become the register pointer
//   byte 2+: data     write: stored to reg[pointer]; read: reg[pointer] on miso
// Register 0 is read-only and always reads DEV_ID; writes to it are dropped.
//
// Build option:
//   SPI_SLV_AUTOINC_EN  defined   -> pointer increments after every data byte
//                                    (burst access, wraps at 2**ADDR_W-1 -> 0)
//                       undefined -> pointer fixed for the whole frame
//
// Ports:
//   clk          system clock (single clock domain)
//   reset        synchronous active-high reset
//   sclk         SPI clock from master (asynchronous to clk)
//   mosi         SPI master-out data
//   ss_n         SPI slave select, active low
//   miso         SPI slave-out data, 0 outside the read-data phase
//   loc_wr       local write strobe
//   loc_addr     local read/write address
//   loc_wr_data  local write data
//   loc_rd_data  registered read data for reg[loc_addr]
//   spi_wr_stb   one-cycle pulse when an SPI write commits a byte
//   spi_wr_addr  address of the committed SPI write
//   cmd_err      one-cycle pulse on an unrecognised command byte
// -----------------------------------------------------------------------------
module spi_slave_regs #(
  parameter int         ADDR_W = 6,
  parameter logic [7:0] DEV_ID = 8'hAD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  input  logic              loc_wr,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wr_data,
  output logic [7:0]        loc_rd_data,
  output logic              spi_wr_stb,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic              cmd_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection
  // Index 0 is the metastability-catching stage, index 1 the synchronised
  // value, index 2 (where present) the previous synchronised value.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [2:0] ss_sync;
  logic [1:0] ss_fill;   // fills with 1s after reset: ss_sync[1] holds a real sample
  logic       ss_armed;  // ss_n has been seen high since reset

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      // ss_n stages come out of reset deselected so a frame already in
      // progress is not mistaken for a fresh select.
      ss_sync   <= '1;
      ss_fill   <= '0;
      ss_armed  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_sync   <= {ss_sync[1:0], ss_n};
      ss_fill   <= {ss_fill[0], 1'b1};
      // Only a genuine high ss_n sample (not a reset value) arms frame start,
      // so a frame cut by reset stays ignored until ss_n goes high then low.
      if (ss_fill[1] && ss_sync[1]) begin
        ss_armed <= 1'b1;
      end
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic ss_high;
  logic ss_fall;
  logic mosi_bit;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_high   = ss_sync[1];
  assign ss_fall   = ss_armed & ss_sync[2] & ~ss_sync[1];
  assign mosi_bit  = mosi_sync[1];

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;
  logic [2:0]        bit_cnt;     // rising edges seen in the current byte
  logic [6:0]        rx_shift;    // first seven bits of the byte being received
  logic [7:0]        tx_shift;    // read data, MSB drives miso
  logic [ADDR_W-1:0] pointer;
  logic              cmd_wr;      // frame direction decided by the command byte
  logic [7:0]        wr_data;     // data accompanying spi_wr_stb
  logic              cmd_bad;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] rx_addr;
  logic [ADDR_W-1:0] ptr_step;
  logic              byte_done;

  // Byte assembled including the bit being sampled this cycle.
  assign rx_byte   = {rx_shift, mosi_bit};
  assign rx_addr   = rx_byte[ADDR_W-1:0];
  // A byte completing as ss_n rises counts as aborted: no write, no pulse.
  assign byte_done = sclk_rise & (bit_cnt == 3'd7) & ~ss_high;

`ifdef SPI_SLV_AUTOINC_EN
  assign ptr_step = pointer + ADDR_W'(1);
`else
  assign ptr_step = pointer;
`endif

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [7:0] regs [DEPTH];

  function automatic logic [7:0] reg_read(input logic [ADDR_W-1:0] a);
    return (a == '0) ? DEV_ID : regs[a];
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so every
      // flop samples the pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is
    // inferred.
    state_next = state;
    cmd_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_next = CMD;
        end
      end
      CMD: begin
        if (byte_done) begin
          if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
            state_next = ADDR;
          end else begin
            state_next = IGNORE;
            cmd_bad    = 1'b1;
          end
        end
      end
      ADDR: begin
        if (byte_done) begin
          state_next = cmd_wr ? WDATA : RDATA;
        end
      end
      WDATA, RDATA, IGNORE: begin
        state_next = state;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Deselect ends the frame from any state.
    if (state != IDLE && ss_high) begin
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift registers, pointer and SPI write request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      pointer     <= '0;
      cmd_wr      <= 1'b0;
      wr_data     <= '0;
      spi_wr_stb  <= 1'b0;
      spi_wr_addr <= '0;
      cmd_err     <= 1'b0;
    end else begin
      spi_wr_stb <= 1'b0;
      cmd_err    <= cmd_bad;

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
      end

      if (byte_done) begin
        case (state)
          CMD: begin
            cmd_wr <= (rx_byte == CMD_WRITE);
          end
          ADDR: begin
            pointer  <= rx_addr;
            // Preload read data so its MSB is on miso before the first data
            // rising edge; harmless for write frames since miso is gated.
            tx_shift <= reg_read(rx_addr);
          end
          WDATA: begin
            if (pointer != '0) begin
              spi_wr_stb  <= 1'b1;
              spi_wr_addr <= pointer;
              wr_data     <= rx_byte;
            end
            pointer <= ptr_step;
          end
          RDATA: begin
            pointer  <= ptr_step;
            tx_shift <= reg_read(ptr_step);
          end
          default: begin
          end
        endcase
      end else if (state == RDATA && sclk_fall && bit_cnt != 3'd0) begin
        // The falling edge right after a (re)load belongs to the previous
        // byte and must not shift; bit_cnt is 0 exactly then.
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign miso = (state == RDATA) & tx_shift[7];

  // ---------------------------------------------------------------------------
  // Register storage and local port. Register 0 is never stored; reads of
  // address 0 return DEV_ID instead.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the register file is reset explicitly because its cleared state
      // is architecturally visible; this keeps it in flops, not RAM.
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      loc_rd_data <= '0;
    end else begin
      if (spi_wr_stb) begin
        regs[spi_wr_addr] <= wr_data;
      end
      // SPI wins a same-address collision; distinct addresses both land.
      if (loc_wr && loc_addr != '0 && !(spi_wr_stb && spi_wr_addr == loc_addr)) begin
        regs[loc_addr] <= loc_wr_data;
      end
      loc_rd_data <= reg_read(loc_addr);
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_regs
//
// Bench for spi_slave_regs. Stimulus tasks play SPI master (sclk = clk/8) and
// drive the local port; expected spi_wr_stb addresses, cmd_err pulses, miso
// data bytes and local read data are queued as stimulus is issued, and a
// monitor on the falling clk edge pops and compares whenever the DUT presents
// the corresponding output.
// -----------------------------------------------------------------------------
module tb_spi_slave_regs;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic              mosi;
  logic              ss_n;
  logic              miso;
  logic              loc_wr;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0]        loc_wr_data;
  logic [7:0]        loc_rd_data;
  logic              spi_wr_stb;
  logic [ADDR_W-1:0] spi_wr_addr;
  logic              cmd_err;

  always #5 clk = ~clk;

  spi_slave_regs #(
    .ADDR_W (ADDR_W),
    .DEV_ID (8'hAD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .loc_wr      (loc_wr),
    .loc_addr    (loc_addr),
    .loc_wr_data (loc_wr_data),
    .loc_rd_data (loc_rd_data),
    .spi_wr_stb  (spi_wr_stb),
    .spi_wr_addr (spi_wr_addr),
    .cmd_err     (cmd_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] exp_wr[$];
  logic              exp_err[$];
  logic [7:0]        exp_miso[$];
  logic [7:0]        obs_miso[$];
  logic [7:0]        exp_rd[$];
  logic              rd_sample = 1'b0;

  logic              collide_armed = 1'b0;
  logic [ADDR_W-1:0] collide_addr = '0;

  logic [7:0]        tx_buf[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (spi_wr_stb) begin
        if (exp_wr.size() == 0) check("spi_wr_stb_unexpected", 32'(spi_wr_addr), 32'hFFFF_FFFF);
        else                    check("spi_wr_addr", 32'(spi_wr_addr), 32'(exp_wr.pop_front()));
      end
      if (cmd_err) begin
        if (exp_err.size() == 0) check("cmd_err_unexpected", 32'(cmd_err), 32'd0);
        else                     check("cmd_err", 32'(cmd_err), 32'(exp_err.pop_front()));
      end
      if (rd_sample) begin
        if (exp_rd.size() == 0) check("loc_rd_unexpected", 32'(loc_rd_data), 32'hFFFF_FFFF);
        else                    check("loc_rd_data", 32'(loc_rd_data), 32'(exp_rd.pop_front()));
      end
      while (obs_miso.size() > 0) begin
        logic [7:0] b;
        b = obs_miso.pop_front();
        if (exp_miso.size() == 0) check("miso_byte_unexpected", 32'(b), 32'hFFFF_FFFF);
        else                      check("miso_byte", 32'(b), 32'(exp_miso.pop_front()));
      end
    end
  end

  // Fires a local write into the very cycle an SPI write commits.
  always @(negedge clk) begin
    if (collide_armed && spi_wr_stb) begin
      collide_armed = 1'b0;
      loc_addr      = collide_addr;
      loc_wr_data   = 8'h99;
      loc_wr        = 1'b1;
      @(posedge clk);
      #1;
      loc_wr = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(4);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  // Full frame of nbytes from tx_buf. In read frames, bytes 2+ go to the
  // scoreboard; every other byte must have seen miso low.
  task automatic spi_frame(input int nbytes, input bit is_read, input string name);
    logic [7:0] rx;
    logic [7:0] idle_or;
    idle_or = '0;
    ss_n = 1'b0;
    wait_clk(4);
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(tx_buf[b], 8, rx);
      if (is_read && b >= 2) obs_miso.push_back(rx);
      else                   idle_or |= rx;
    end
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(8);
    check({name, "_miso_low"}, 32'(idle_or), 32'd0);
  endtask

  task automatic local_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    loc_addr    = a;
    loc_wr_data = d;
    loc_wr      = 1'b1;
    wait_clk(1);
    loc_wr = 1'b0;
  endtask

  task automatic local_read(input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    loc_addr = a;
    exp_rd.push_back(exp);
    wait_clk(1);
    rd_sample = 1'b1;
    wait_clk(1);
    rd_sample = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    reset       = 1'b1;
    sclk        = 1'b0;
    mosi        = 1'b0;
    ss_n        = 1'b1;
    loc_wr      = 1'b0;
    loc_addr    = '0;
    loc_wr_data = '0;
    wait_clk(5);

    // Reset state, sampled while reset is still asserted.
    check("rst_loc_rd_data", 32'(loc_rd_data), 32'd0);
    check("rst_miso",        32'(miso),        32'd0);
    check("rst_spi_wr_stb",  32'(spi_wr_stb),  32'd0);
    check("rst_spi_wr_addr", 32'(spi_wr_addr), 32'd0);
    check("rst_cmd_err",     32'(cmd_err),     32'd0);
    reset = 1'b0;
    wait_clk(4);
    local_read(0, 8'hAD);
    local_read(5, 8'h00);

    // Single write.
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h05; tx_buf[2] = 8'h3C;
    exp_wr.push_back(6'd5);
    spi_frame(3, 1'b0, "wr5");
    local_read(5, 8'h3C);

    // Read of two bytes starting at 7.
    local_write(7, 8'h5A);
    local_write(8, 8'hA5);
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h07; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    exp_miso.push_back(8'h5A);
`ifdef SPI_SLV_AUTOINC_EN
    exp_miso.push_back(8'hA5);
`else
    exp_miso.push_back(8'h5A);
`endif
    spi_frame(4, 1'b1, "rd7");

    // Register 0: reads DEV_ID, writes are dropped.
    tx_buf[0] = 8'h0B; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    exp_miso.push_back(8'hAD);
    spi_frame(3, 1'b1, "rd0");
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h00; tx_buf[2] = 8'hFF;
    spi_frame(3, 1'b0, "wr0");
    local_read(0, 8'hAD);

    // Two data bytes at the top address.
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h3F; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22;
    exp_wr.push_back(6'd63);
`ifdef SPI_SLV_AUTOINC_EN
    spi_frame(4, 1'b0, "burst");
    local_read(63, 8'h11);
`else
    exp_wr.push_back(6'd63);
    spi_frame(4, 1'b0, "burst");
    local_read(63, 8'h22);
`endif
    local_read(0, 8'hAD);

    // Unknown command: one cmd_err, the rest of the frame ignored.
    tx_buf[0] = 8'h55; tx_buf[1] = 8'h0A; tx_buf[2] = 8'h04;
    exp_err.push_back(1'b1);
    spi_frame(3, 1'b0, "badcmd");
    local_read(4, 8'h00);

    // Abort after 4 bits of the data byte: nothing stored.
    ss_n = 1'b0;
    wait_clk(4);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h09, 8, rx);
    spi_bits(8'hC3, 4, rx);
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(8);
    local_read(9, 8'h00);

    // Same-cycle collision: SPI wins on the same address.
    collide_addr = 6'd12;
    collide_armed = 1'b1;
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h0C; tx_buf[2] = 8'h66;
    exp_wr.push_back(6'd12);
    spi_frame(3, 1'b0, "coll_same");
    local_read(12, 8'h66);

    // Same-cycle writes to different addresses both land.
    collide_addr = 6'd13;
    collide_armed = 1'b1;
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h0E; tx_buf[2] = 8'h67;
    exp_wr.push_back(6'd14);
    spi_frame(3, 1'b0, "coll_diff");
    local_read(14, 8'h67);
    local_read(13, 8'h99);

    // Reset in the middle of a write frame; the rest of that frame is ignored.
    ss_n = 1'b0;
    wait_clk(4);
    spi_bits(8'h0A, 8, rx);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hFF, 3, rx);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    spi_bits(8'hFF, 5, rx);
    spi_bits(8'hEE, 8, rx);
    wait_clk(4);
    ss_n = 1'b1;
    wait_clk(8);
    local_read(2, 8'h00);
    local_read(5, 8'h00);
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h02; tx_buf[2] = 8'h77;
    exp_wr.push_back(6'd2);
    spi_frame(3, 1'b0, "wr_after_rst");
    local_read(2, 8'h77);

    wait_clk(10);
    check("exp_wr_drained",   32'(exp_wr.size()),   32'd0);
    check("exp_err_drained",  32'(exp_err.size()),  32'd0);
    check("exp_miso_drained", 32'(exp_miso.size()), 32'd0);
    check("exp_rd_drained",   32'(exp_rd.size()),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 Parameter ADDR_W, default 6, register-file address width (2**ADDR_W bytes).
REQ-002 Parameter DEV_ID, default 8'hAD, read-only contents of register 0.
REQ-003 Port clk, input, 1, system clock; all logic is single clock domain.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port sclk, input, 1, SPI clock from master, asynchronous to clk.
REQ-006 Port mosi, input, 1, SPI master-out data.
REQ-007 Port ss_n, input, 1, SPI slave select, active-low.
REQ-008 Port miso, output, 1, SPI slave-out data.
REQ-009 Port loc_wr, input, 1, local write strobe.
REQ-010 Port loc_addr, input, ADDR_W, local read/write address.
REQ-011 Port loc_wr_data, input, 8, local write data.
REQ-012 Port loc_rd_data, output, 8, registered local read data for reg[loc_addr].
REQ-013 Port spi_wr_stb, output, 1, one-cycle pulse when an SPI write commits a byte.
REQ-014 Port spi_wr_addr, output, ADDR_W, address of the committed SPI write.
REQ-015 Port cmd_err, output, 1, one-cycle pulse on unrecognised command byte.

Function
REQ-016 sclk, mosi and ss_n SHALL pass through 2-FF synchronisers; edges detected on synchronised values.
REQ-017 Protocol SHALL be SPI mode 0, MSB first: mosi sampled on sclk rise, miso updated on sclk fall.
REQ-018 Supported sclk SHALL be at most clk/8; slower is unrestricted.
REQ-019 FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-020 IDLE -> CMD on synchronised ss_n falling edge; 3-bit bit counter cleared.
REQ-021 CMD: after 8 bits, 8'h0A -> ADDR (write), 8'h0B -> ADDR (read), any other value -> IGNORE with cmd_err pulse.
REQ-022 ADDR: after 8 bits, low ADDR_W bits latched as pointer; upper bits ignored; -> WDATA or RDATA.
REQ-023 WDATA: each completed byte written to reg[pointer] in the cycle after the 8th rising edge is detected, with spi_wr_stb high and spi_wr_addr = pointer.
REQ-024 Writes to address 0 SHALL be discarded (no store, no spi_wr_stb); register 0 always reads DEV_ID.
REQ-025 RDATA: reg[pointer] loaded into tx shift register on the cycle the address byte completes and on each subsequent byte completion; miso = shift-register MSB.
REQ-026 Pointer SHALL advance per completed data byte per Configuration, wrapping 2**ADDR_W-1 -> 0.
REQ-027 miso SHALL be 0 in IDLE, CMD, ADDR, WDATA and IGNORE.
REQ-028 ss_n rising in any state -> IDLE next cycle; partial byte discarded, no write, no pulse.
REQ-029 Local write stores loc_wr_data to reg[loc_addr] (address 0 discarded); loc_rd_data updates one cycle after loc_addr.
REQ-030 SPI write and loc_wr to same address in same cycle: SPI data stored, local write dropped; different addresses both stored.
REQ-031 IGNORE: all sclk activity ignored until ss_n rises.

Reset
REQ-032 On reset: FSM IDLE, counters and pointer 0, miso 0, spi_wr_stb 0, spi_wr_addr 0, cmd_err 0, loc_rd_data 0, registers 1..N-1 cleared to 0.
REQ-033 Synchroniser ss_n stages SHALL reset to 1; a frame in progress at reset release is ignored until ss_n goes high then low.

Configuration
REQ-034 Macro SPI_SLV_AUTOINC_EN defined: pointer increments after each completed data byte (burst access).
REQ-035 Macro SPI_SLV_AUTOINC_EN undefined: pointer constant for the frame; every data byte accesses the same register.

Verification
REQ-036 Write frame 0A,05,3C at clk/8 -> reg[5]=3C, one spi_wr_stb with spi_wr_addr=5; local read of 5 returns 3C.
REQ-037 Local write reg[7]=5A, reg[8]=A5; read frame 0B,07,xx,xx -> miso bytes 5A,A5 (AUTOINC_EN) or 5A,5A (undefined).
REQ-038 Read frame 0B,00,xx -> miso DEV_ID 8'hAD; write frame 0A,00,FF -> no spi_wr_stb, reg 0 still AD.
REQ-039 Burst write 0A,3F,11,22 with AUTOINC_EN -> reg[63]=11, reg[0] unchanged (wrap, discarded), stb only for address 63.
REQ-040 Command 8'h55 then 16 clocks -> one cmd_err pulse, miso 0, no writes; ss_n abort after 4 bits of data byte -> no write.
REQ-041 Reset asserted mid-write-frame then released with ss_n low -> remaining bits ignored; next full frame 0A,02,77 -> reg[2]=77.
